// File: rtl/info_key_route_merge_if.sv
// rtl/info_key_route_merge_if.sv - source/destination stream bundle for info_key_route_merge
interface info_key_route_merge_if #(
    parameter int SRC_W     = 2,
    parameter int DST_W     = 2,
    parameter int KEY_W     = 12,
    parameter int PAYLOAD_W = 48,
    parameter int FIFO_AW   = 4
);
    localparam int NS = 2 ** SRC_W;
    localparam int ND = 2 ** DST_W;
    localparam int IW = KEY_W + PAYLOAD_W;
    localparam int LW = FIFO_AW + 1;

    logic [NS-1:0]    s_valid;
    logic [NS-1:0]    s_ready;
    logic [NS*IW-1:0] s_info;
    logic [ND-1:0]    m_valid;
    logic [ND-1:0]    m_ready;
    logic [ND*IW-1:0] m_info;
    logic [ND*LW-1:0] m_level;

    modport slave  (input  s_valid, s_info, m_ready, output s_ready, m_valid, m_info, m_level);
    modport master (output s_valid, s_info, m_ready, input  s_ready, m_valid, m_info, m_level);
endinterface

// File: rtl/info_key_route_merge.sv
// rtl/info_key_route_merge.sv - merge NS keyed sources into ND per-destination show-ahead FIFOs
// Optional route counter output enabled by defining INFO_ROUTE_CNT_EN.
module info_key_route_merge #(
    parameter int SRC_W     = 2,
    parameter int DST_W     = 2,
    parameter int KEY_W     = 12,
    parameter int PAYLOAD_W = 48,
    parameter int FIFO_AW   = 4,
    parameter int MODE      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_finish,
    info_key_route_merge_if.slave bus,
    output logic                  busy
`ifdef INFO_ROUTE_CNT_EN
    ,
    output logic [31:0]           route_cnt
`endif
);
    localparam int NS    = 2 ** SRC_W;
    localparam int ND    = 2 ** DST_W;
    localparam int IW    = KEY_W + PAYLOAD_W;
    localparam int LW    = FIFO_AW + 1;
    localparam int DEPTH = 2 ** FIFO_AW;

    logic               start_q, start_d;
    logic [SRC_W-1:0]   rr_q, rr_d;
    logic               pipe_vld_q, pipe_vld_d;
    logic [DST_W-1:0]   pipe_dst_q, pipe_dst_d;
    logic [IW-1:0]      pipe_info_q, pipe_info_d;
    logic [IW-1:0]      mem_q [ND][DEPTH];
    logic [IW-1:0]      mem_d [ND][DEPTH];
    logic [FIFO_AW-1:0] wptr_q [ND];
    logic [FIFO_AW-1:0] wptr_d [ND];
    logic [FIFO_AW-1:0] rptr_q [ND];
    logic [FIFO_AW-1:0] rptr_d [ND];
    logic [LW-1:0]      level_q [ND];
    logic [LW-1:0]      level_d [ND];

    logic [KEY_W-1:0]   key_s [NS];
    logic               found;
    logic [SRC_W-1:0]   gnt;
    logic [ND-1:0]      pop;
    logic               push_ok;
    logic               can_grant;
    logic               accept;

    // MODE 0 keeps the strictly smaller key, so ties stay with the lower index.
    always_comb begin : arbiter
        int idx;
        idx   = 0;
        found = 1'b0;
        gnt   = '0;
        for (int i = 0; i < NS; i++) key_s[i] = bus.s_info[i*IW + PAYLOAD_W +: KEY_W];
        for (int k = 0; k < NS; k++) begin
            idx = (MODE == 1) ? (int'(rr_q) + k) % NS : k;
            if (bus.s_valid[idx] && (!found || (MODE == 0 && key_s[idx] < key_s[gnt]))) begin
                found = 1'b1;
                gnt   = SRC_W'(idx);
            end
        end
    end

    // A full FIFO still accepts the pipeline entry when its head is popped this cycle.
    always_comb begin : flow
        for (int d = 0; d < ND; d++) pop[d] = (level_q[d] != '0) && bus.m_ready[d];
        push_ok     = pipe_vld_q && ((level_q[pipe_dst_q] != LW'(DEPTH)) || pop[pipe_dst_q]);
        can_grant   = start_q && !rst && (!pipe_vld_q || push_ok);
        accept      = can_grant && found;
        bus.s_ready = accept ? (NS'(1) << gnt) : '0;
    end

    always_comb begin : next_state
        start_d     = start_q | in_finish;
        rr_d        = accept ? gnt + 1'b1 : rr_q;
        pipe_vld_d  = accept || (pipe_vld_q && !push_ok);
        pipe_dst_d  = accept ? key_s[gnt][DST_W-1:0] : pipe_dst_q;
        pipe_info_d = accept ? bus.s_info[int'(gnt)*IW +: IW] : pipe_info_q;
        mem_d       = mem_q;
        for (int d = 0; d < ND; d++) begin
            wptr_d[d]  = wptr_q[d];
            rptr_d[d]  = rptr_q[d];
            level_d[d] = level_q[d];
            if (push_ok && pipe_dst_q == DST_W'(d)) begin
                mem_d[d][wptr_q[d]] = pipe_info_q;
                wptr_d[d]           = wptr_q[d] + 1'b1;
                level_d[d]          = level_d[d] + LW'(1);
            end
            if (pop[d]) begin
                rptr_d[d]  = rptr_q[d] + 1'b1;
                level_d[d] = level_d[d] - LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q     <= 1'b0;
            rr_q        <= '0;
            pipe_vld_q  <= 1'b0;
            pipe_dst_q  <= '0;
            pipe_info_q <= '0;
            for (int d = 0; d < ND; d++) begin
                wptr_q[d]  <= '0;
                rptr_q[d]  <= '0;
                level_q[d] <= '0;
            end
        end else begin
            start_q     <= start_d;
            rr_q        <= rr_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_dst_q  <= pipe_dst_d;
            pipe_info_q <= pipe_info_d;
            for (int d = 0; d < ND; d++) begin
                wptr_q[d]  <= wptr_d[d];
                rptr_q[d]  <= rptr_d[d];
                level_q[d] <= level_d[d];
            end
        end
    end

    // Storage needs no reset: m_info is masked whenever a FIFO is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin : outputs
        bus.m_valid = '0;
        bus.m_level = '0;
        bus.m_info  = '0;
        for (int d = 0; d < ND; d++) begin
            bus.m_valid[d]             = level_q[d] != '0;
            bus.m_level[d*LW +: LW]    = level_q[d];
            bus.m_info[d*IW +: IW]     = (level_q[d] != '0) ? mem_q[d][rptr_q[d]] : '0;
        end
    end

    assign busy = pipe_vld_q;

`ifdef INFO_ROUTE_CNT_EN
    logic [31:0] route_cnt_q, route_cnt_d;

    always_comb begin
        route_cnt_d = (push_ok && route_cnt_q != '1) ? route_cnt_q + 32'd1 : route_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) route_cnt_q <= '0;
        else     route_cnt_q <= route_cnt_d;
    end

    assign route_cnt = route_cnt_q;
`endif
endmodule
